imem_rsp: RTL and testbench
===========================

# imem_rsp

Instruction-memory responder: the memory-side end of the instruction fetch interface. It accepts the fetch stage's `inst_addr` and returns the addressed 32-bit instruction on `inst_out`, which drives the fetch stage's `inst_in`, with registered one-cycle latency. After reset it loads its program from a byte-serial loader stream (valid/ready handshake), then switches permanently to serving fetches. It sits beside the fetch pipeline stage in the core top level; widths come from `cpu_attr.v` (`INST_ADDR_WIDTH`).

## Interface
- `DEPTH_LOG2`, default 8: log2 of word capacity (256 words); requires `DEPTH_LOG2 + 2 <= INST_ADDR_WIDTH`.
- `clk`  in  1  single clock, all logic on its rising edge.
- `_rst`  in  1  synchronous, active-low reset.
- `inst_addr`  in  `INST_ADDR_WIDTH`  byte address from fetch stage.
- `inst_out`  out  32  instruction for `inst_addr` sampled one edge earlier.
- `inst_valid`  out  1  `inst_out` holds a fetched word.
- `ld_valid`  in  1  loader byte present.
- `ld_byte`  in  8  loader byte.
- `ld_last`  in  1  qualifies the final byte of the program.
- `ld_ready`  out  1  responder accepts a byte this cycle.
- `ld_done`  out  1  load finished, serving fetches.
- `misalign`  out  1  fetched address was not word aligned (see Configuration).

## Operation
- States: LOAD and RUN. Reset enters LOAD. RUN is left only through reset.
- Reset values: `inst_out = 32'h00000013` (NOP), `inst_valid = 0`, `ld_ready = 1`, `ld_done = 0`, `misalign = 0`. Word pointer `wptr`, byte counter `bcnt`, and loaded-word count `wcnt` are cleared to 0. Memory array contents are not reset.
- LOAD:
  - `ld_ready = 1`. Each cycle with `ld_valid & ld_ready`, `ld_byte` goes into lane `bcnt`, little-endian: byte 0 is bits 7:0.
  - On the 4th byte, the assembled word is written to `mem[wptr]`; `wptr` and `wcnt` increment and `bcnt` returns to 0.
  - Handshake with `ld_last = 1`: the current word is written immediately, with unfilled upper lanes zero; `wcnt` increments; state becomes RUN.
  - Overflow: a write to `wptr = 2^DEPTH_LOG2 - 1` without `ld_last` also forces RUN. Further bytes are never accepted.
  - Fetch side during LOAD: `inst_out` holds NOP and `inst_valid` stays 0.
- RUN:
  - `ld_ready = 0` and `ld_done = 1`. `ld_valid` is ignored.
  - Word index = `inst_addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so addresses wrap modulo capacity.
  - Every cycle: `inst_out <= (index < wcnt) ? mem[index] : NOP`, and `inst_valid <= 1`.
- Reset during LOAD or RUN returns to LOAD with `wcnt = 0`. All reads then return NOP until reloaded.
- Reads never stall; the fetch stage may change `inst_addr` every cycle, including on a jump.

## Timing
- `ld_ready` and `ld_done` are decoded from the state register, with no combinational path from inputs.
- The byte carrying `ld_last` is accepted at edge E. `ld_done` and state RUN are visible from E.
- The first fetch address is sampled at edge E+1. `inst_out` and `inst_valid = 1` are valid after E+1.
- Read latency is exactly one edge: the address presented in cycle N gives data in cycle N+1. Back-to-back addresses give back-to-back data.
- Minimum load time is one byte per cycle; `ld_valid` gaps simply pause assembly.

## Configuration
- `IMEM_ALIGN_CHECK_EN` defined:
  - `misalign` is registered alongside `inst_out` and equals `|inst_addr[1:0]` of the sampled address.
  - When `misalign` is 1, `inst_out` is forced to NOP, and `inst_valid` still follows the normal rules.
- Not defined: `misalign` is constant 0 and low address bits are silently ignored.

## Test plan
- Reset, then stream bytes 13,00,00,00,93,00,A0,00 with `ld_last` on the 8th byte -> `wcnt = 2`, `ld_done = 1`. Fetching 0x0 then 0x4 returns 32'h00000013 then 32'h00A00093 on consecutive cycles, one cycle after each address.
- Load 6 bytes 11,22,33,44,55,66 with `ld_last` on the 6th -> word 1 reads 32'h00006655. Fetching 0x8 returns NOP.
- Drop `ld_valid` for 3 cycles mid-word -> assembled word is unchanged and `ld_ready` stays 1 throughout.
- After load, fetch 0x0 and then jump to 0xAB (`DEPTH_LOG2 = 8`) -> index 42 is returned the next cycle. With `IMEM_ALIGN_CHECK_EN`, `misalign = 1` and `inst_out` is NOP.
- Pull `_rst` low for one edge while in RUN -> outputs return to reset values and `ld_ready = 1`. Fetch 0x0 while still in LOAD -> NOP with `inst_valid = 0`.
- Stream `2^DEPTH_LOG2 * 4` bytes without `ld_last` -> RUN is entered after the last word. `ld_ready = 0` and later bytes are ignored.

Source files
------------

// File: rtl/imem_rsp.sv
// Instruction-memory responder: loads a program from a byte-serial stream, then serves
// registered one-cycle fetches. Optional misalignment detection: define IMEM_ALIGN_CHECK_EN.
module imem_rsp #(
  parameter int INST_ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2      = 8
) (
  input  logic                       clk,
  input  logic                       _rst,
  input  logic [INST_ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]                inst_out,
  output logic                       inst_valid,
  input  logic                       ld_valid,
  input  logic [7:0]                 ld_byte,
  input  logic                       ld_last,
  output logic                       ld_ready,
  output logic                       ld_done,
  output logic                       misalign,
  output logic                       fsm_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  // Loader handshake: a byte transfers on any rising edge where ld_valid and ld_ready are both 1.
  // ld_ready is a pure function of the state register, so ld_valid may be raised at any time.
  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] wptr;
  logic [1:0]            bcnt;
  logic [DEPTH_LOG2:0]   wcnt;
  logic [31:0]           asm_word;
  logic [31:0]           word_fill;
  logic [31:0]           mem [DEPTH];
  logic                  accept;
  logic                  word_end;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]           rd_word;
  logic                  mis_q;
  logic                  unused_addr_bits;

  assign accept   = ld_valid & ld_ready;
  assign word_end = accept & ((bcnt == 2'd3) | ld_last);

  // State register
  always_ff @(posedge clk) begin
    if (!_rst) state <= LOAD;
    else       state <= state_nxt;
  end

  // Next state: a word written at the top slot ends the load even without ld_last
  always_comb begin
    state_nxt = state;
    if (state == LOAD && word_end && (ld_last || (&wptr)))
      state_nxt = RUN;
  end

  // Outputs decoded from state
  always_comb begin
    ld_ready  = (state == LOAD);
    ld_done   = (state == RUN);
    fsm_state = state;
  end

  // Current word with the incoming byte merged into lane bcnt; unfilled lanes stay zero
  always_comb begin
    word_fill = asm_word;
    word_fill[{bcnt, 3'b000} +: 8] = ld_byte;
  end

  always_ff @(posedge clk) begin
    if (!_rst) begin
      wptr     <= '0;
      bcnt     <= '0;
      wcnt     <= '0;
      asm_word <= '0;
    end else if (accept) begin
      if (word_end) begin
        asm_word <= '0;
        bcnt     <= '0;
        wptr     <= wptr + 1'b1;
        wcnt     <= wcnt + 1'b1;
      end else begin
        asm_word <= word_fill;
        bcnt     <= bcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_end) mem[wptr] <= word_fill;
  end

  assign rd_idx  = inst_addr[DEPTH_LOG2+1:2];
  assign rd_word = ({1'b0, rd_idx} < wcnt) ? mem[rd_idx] : NOP;

  always_ff @(posedge clk) begin
    if (!_rst) begin
      inst_out   <= NOP;
      inst_valid <= 1'b0;
      mis_q      <= 1'b0;
    end else if (state == RUN) begin
      inst_valid <= 1'b1;
`ifdef IMEM_ALIGN_CHECK_EN
      mis_q      <= |inst_addr[1:0];
      inst_out   <= (|inst_addr[1:0]) ? NOP : rd_word;
`else
      mis_q      <= 1'b0;
      inst_out   <= rd_word;
`endif
    end
  end

  assign misalign = mis_q;

  // Upper address bits wrap; low bits matter only with the alignment check
  assign unused_addr_bits = ^{inst_addr[INST_ADDR_WIDTH-1:DEPTH_LOG2+2], inst_addr[1:0]};

endmodule

// File: tb/tb_imem_rsp.sv
// Bench for imem_rsp: fixed program vectors, gap/reset/overflow sequences, and random
// loads checked against a byte-list memory model.
module tb_imem_rsp;

  localparam int DEPTH_LOG2 = 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        _rst;
  logic [31:0] inst_addr;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic        misalign;
  logic        fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_mem [DEPTH];
  int          m_wcnt;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  imem_rsp #(.INST_ADDR_WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), ._rst(_rst), .inst_addr(inst_addr), .inst_out(inst_out),
    .inst_valid(inst_valid), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .misalign(misalign), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model: bytes fill words little-endian; capacity caps the loaded word count
  task automatic build_model(input logic [7:0] bq[$]);
    int n;
    n = (bq.size() > DEPTH * 4) ? DEPTH * 4 : bq.size();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int i = 0; i < n; i++) m_mem[i / 4][8 * (i % 4) +: 8] = bq[i];
    m_wcnt = (n + 3) / 4;
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int idx;
    idx = int'((a >> 2) % DEPTH);
    if (ALIGN_EN && (a % 4) != 0) return NOP;
    return (idx < m_wcnt) ? m_mem[idx] : NOP;
  endfunction

  task automatic do_reset();
    _rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    _rst = 1'b1;
    check("rst_inst_out", inst_out, NOP);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    check("rst_ld_done", {31'd0, ld_done}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
  endtask

  task automatic load_bytes(input logic [7:0] bq[$], input bit use_last,
                            input int gap_at, input int gap_len, input int max_gap);
    int gap;
    for (int i = 0; i < bq.size(); i++) begin
      gap = $urandom_range(0, max_gap);
      if (i == gap_at) gap = gap_len;
      repeat (gap) begin
        ld_valid = 1'b0; ld_byte = 8'($urandom); ld_last = 1'($urandom);
        tick();
        check("ld_ready_gap", {31'd0, ld_ready}, 32'd1);
      end
      check("ld_ready_load", {31'd0, ld_ready}, 32'd1);
      ld_valid = 1'b1; ld_byte = bq[i]; ld_last = use_last && (i == bq.size() - 1);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("done_after_load", {31'd0, ld_done}, 32'd1);
    check("ready_after_load", {31'd0, ld_ready}, 32'd0);
    check("valid_at_load_end", {31'd0, inst_valid}, 32'd0);
    build_model(bq);
  endtask

  task automatic fetch(input logic [31:0] a);
    inst_addr = a;
    exp_q.push_back(ref_word(a));
    tick();
    check("fetch_data", inst_out, exp_q.pop_front());
    check("fetch_valid", {31'd0, inst_valid}, 32'd1);
    check("fetch_misalign", {31'd0, misalign}, {31'd0, ALIGN_EN && (a[1:0] != 2'b00)});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[$];
    vecs[0] = '{32'h0000_0000, 32'h0000_0013};
    vecs[1] = '{32'h0000_0004, 32'h00A0_0093};
    vecs[2] = '{32'h0000_0008, NOP};
    vecs[3] = '{32'h0000_0400, 32'h0000_0013};
    vecs[4] = '{32'hFFFF_FC04, 32'h00A0_0093};
    vecs[5] = '{32'h0000_00A8, NOP};

    _rst = 1'b0; inst_addr = '0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    tick();
    do_reset();

    // Fetch while still loading: outputs stay at NOP / not valid
    inst_addr = 32'h0;
    tick();
    check("load_fetch_data", inst_out, NOP);
    check("load_fetch_valid", {31'd0, inst_valid}, 32'd0);

    // Two-word program, then table vectors applied back-to-back
    bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    load_bytes(bq, 1'b1, -1, 0, 0);
    check("wcnt_two", m_wcnt, 2);
    for (int i = 0; i < 6; i++) begin
      inst_addr = vecs[i].addr;
      tick();
      check($sformatf("vec%0d_data", i), inst_out, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), {31'd0, inst_valid}, 32'd1);
    end

    // Reset in RUN, then 6-byte load with a 3-cycle stall mid-word
    do_reset();
    inst_addr = 32'h0;
    tick();
    check("reload_fetch_data", inst_out, NOP);
    check("reload_fetch_valid", {31'd0, inst_valid}, 32'd0);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    load_bytes(bq, 1'b1, 2, 3, 0);
    inst_addr = 32'h0;  tick(); check("six_w0", inst_out, 32'h4433_2211);
    inst_addr = 32'h4;  tick(); check("six_w1", inst_out, 32'h0000_6655);
    inst_addr = 32'h8;  tick(); check("six_w2", inst_out, NOP);

    // Random program with random stalls, jump to a misaligned address, random fetches
    do_reset();
    bq.delete();
    repeat (200) bq.push_back(8'($urandom));
    load_bytes(bq, 1'b1, -1, 0, 2);
    fetch(32'h0);
    fetch(32'hAB);
    fetch(32'hA8);
    repeat (150) fetch($urandom);
    repeat (50) fetch(32'($urandom_range(0, 255)) << 2);

    // Overflow: full capacity without ld_last, later bytes ignored
    do_reset();
    bq.delete();
    repeat (DEPTH * 4) bq.push_back(8'($urandom));
    load_bytes(bq, 1'b0, -1, 0, 0);
    check("wcnt_full", m_wcnt, DEPTH);
    repeat (8) begin
      ld_valid = 1'b1; ld_byte = 8'($urandom); ld_last = 1'($urandom);
      tick();
      check("overflow_ready", {31'd0, ld_ready}, 32'd0);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    for (int i = 0; i < DEPTH; i++) fetch(32'(i) << 2);
    repeat (100) fetch($urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
